// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: sync, edge-latch, mask, fixed-priority select, req/ack/eoi handshake; optional nesting via INTC_NESTING_EN.
// Latency: i_ext high at edge k -> pending at k+2 -> irq at k+3; irq held until ack or source withdrawn.
module ext_irq_ctrl #(
  parameter int NUM_SRC    = 31,
  parameter int NEST_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [30:0] i_ext,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [30:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        irq,
  output logic [4:0]  irq_id,
  input  logic        irq_ack,
  input  logic        irq_eoi
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;
  localparam logic [30:0] SRC_MASK = 31'((64'd1 << NUM_SRC) - 64'd1);

  logic [30:0] sync1, sync2, sync3;
  logic [30:0] pending, enable;
  logic [30:0] rise, eligible, w1c, ack_clr, pending_nxt, enable_nxt;
  logic [1:0]  state, state_nxt;
  logic [4:0]  cur_id, id_nxt, sel_id;
  logic        sel_vld, still_elig, act_valid;

  assign rise      = sync2 & ~sync3 & SRC_MASK;
  assign eligible  = pending & enable;
  assign w1c       = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : '0;
  assign ack_clr   = (state == ST_REQ && irq_ack) ? (31'd1 << cur_id) : '0;
  // Clears are applied before the OR so a fresh edge always survives.
  assign pending_nxt = ((pending & ~w1c & ~ack_clr) | rise) & SRC_MASK;
  assign enable_nxt  = (cfg_we && cfg_addr == 2'd0) ? (cfg_wdata & SRC_MASK) : enable;
  // Withdrawal is judged on next-cycle values so irq drops right after a mask or W1C write.
  assign still_elig  = |(((pending & ~w1c) | rise) & enable_nxt & (31'd1 << cur_id));
  assign act_valid   = (state != ST_IDLE);
  assign irq         = (state == ST_REQ);
  assign irq_id      = cur_id;

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_vld = 1'b1;
        sel_id  = 5'(i);
      end
    end
  end

`ifdef INTC_NESTING_EN
  localparam int DW = $clog2(NEST_DEPTH + 1);
  logic [4:0]    stack [NEST_DEPTH];
  logic [DW-1:0] depth;
  logic [4:0]    top_id;
  logic          push, pop;

  always_comb begin
    top_id = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (DW'(i + 1) == depth) top_id = stack[i];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      depth <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) stack[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (DW'(i) == depth) stack[i] <= cur_id;
      end
      depth <= depth + 1'b1;
    end else if (pop) begin
      depth <= depth - 1'b1;
    end
  end
`else
  logic unused_nest;
  assign unused_nest = NEST_DEPTH[0];
`endif

  always_comb begin
    state_nxt = state;
    id_nxt    = cur_id;
`ifdef INTC_NESTING_EN
    push = 1'b0;
    pop  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (sel_vld) begin
          state_nxt = ST_REQ;
          id_nxt    = sel_id;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_nxt = ST_SERV;
        end else if (!still_elig) begin
`ifdef INTC_NESTING_EN
          if (depth != '0) begin
            state_nxt = ST_SERV;
            id_nxt    = top_id;
            pop       = 1'b1;
          end else
`endif
          state_nxt = ST_IDLE;
        end
      end
      ST_SERV: begin
        if (irq_eoi) begin
`ifdef INTC_NESTING_EN
          if (depth != '0) begin
            id_nxt = top_id;
            pop    = 1'b1;
          end else
`endif
          state_nxt = ST_IDLE;
        end
`ifdef INTC_NESTING_EN
        else if (sel_vld && sel_id < cur_id && depth < DW'(NEST_DEPTH)) begin
          push      = 1'b1;
          state_nxt = ST_REQ;
          id_nxt    = sel_id;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      pending <= '0;
      enable  <= '0;
      state   <= ST_IDLE;
      cur_id  <= '0;
    end else begin
      sync1   <= i_ext;
      sync2   <= sync1;
      sync3   <= sync2;
      pending <= pending_nxt;
      enable  <= enable_nxt;
      state   <= state_nxt;
      cur_id  <= id_nxt;
    end
  end

  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = {1'b0, enable};
      2'd1:    cfg_rdata = {1'b0, pending};
      2'd2:    cfg_rdata = {24'b0, state, act_valid, cur_id};
      default: cfg_rdata = '0;
    endcase
  end

endmodule
